// File: rtl/mano_ctrl_pkg.sv
// Shared constants and helpers for the Mano basic-computer timing/control unit.
package mano_ctrl_pkg;

  // Sequence counter width: T0..T7
  localparam int SC_W = 3;

  // Opcode field ir[14:12]
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_LDA  = 3'd2;
  localparam logic [2:0] OP_STA  = 3'd3;
  localparam logic [2:0] OP_BUN  = 3'd4;
  localparam logic [2:0] OP_BSA  = 3'd5;
  localparam logic [2:0] OP_ISZ  = 3'd6;
  localparam logic [2:0] OP_RRIO = 3'd7;

  // AC operation select handed to the datapath
  typedef enum logic [1:0] {
    AC_NONE = 2'b00,
    AC_AND  = 2'b01,
    AC_ADD  = 2'b10,
    AC_LDA  = 2'b11
  } ac_op_e;

  // 3->8 one-hot decode, shared by the timing decode and the opcode decode
  function automatic logic [7:0] onehot3(input logic [2:0] v);
    onehot3 = 8'b0000_0001 << v;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter SC with increment / clear / hold and gated one-hot timing output.
module mano_seq_counter
  import mano_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,       // S flip-flop: count only while running
  input  logic            clr,      // end of instruction (or illegal T7)
  output logic [SC_W-1:0] sc,
  output logic [SC_W-1:0] sc_next,
  output logic [7:0]      t
);

  logic [SC_W-1:0] sc_q;
  logic [SC_W-1:0] sc_d;
  logic [7:0]      dec;

  // Next count: forced to 0 when stopped or at end of instruction
  always_comb begin
    sc_d = sc_q + 3'd1;
    if (!en || clr) begin
      sc_d = '0;
    end
  end

  // SC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign dec     = onehot3(sc_q);
  assign sc      = sc_q;
  assign sc_next = sc_d;

  // Timing lines are all low while the computer is stopped
  for (genvar gi = 0; gi < 8; gi++) begin : g_tgate
    assign t[gi] = en & dec[gi];
  end

endmodule

// File: rtl/mano_timing_ctrl.sv
// Timing/control unit: run flag, opcode/I latches, and per-cycle register strobes.
module mano_timing_ctrl
  import mano_ctrl_pkg::*;
#(
  parameter int START_RUNNING   = 0,
  parameter int CLR_PC_ON_START = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic        dr_zero,
  output logic [7:0]  t,
  output logic [7:0]  d,
  output logic        i_bit,
  output logic        running,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_clr,
  output logic        ar_ld_pc,
  output logic        ar_ld_ir,
  output logic        ar_ld_mem,
  output logic        ar_inc,
  output logic        ir_ld,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        dr_ld,
  output logic        dr_inc,
  output logic [1:0]  ac_op,
  output logic        rr_exec,
  output logic        io_exec,
  output logic        sc_err
);

  logic            s_q, s_d;
  logic [7:0]      d_q, d_d;
  logic            i_q, i_d;
  logic            sc_err_q, sc_err_d;
  logic            sc_clr;
  logic            hlt;
  logic [SC_W-1:0] sc;
  logic [SC_W-1:0] sc_next;
  logic            mem_ref_rd;
  logic            unused_ir;

  // Only the opcode, I bit and HLT bit are inspected here
  assign unused_ir = ^{ir[11:1], sc};

  mano_seq_counter u_sc (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (s_q),
    .clr     (sc_clr),
    .sc      (sc),
    .sc_next (sc_next),
    .t       (t)
  );

  // HLT is a register-reference instruction with ir[0] set
  assign hlt = t[3] & d_q[OP_RRIO] & ~i_q & ir[0];

  // End-of-instruction detect; T7 is illegal and always wraps back to T0
  always_comb begin
    sc_clr = t[7]
           | (t[3] & d_q[OP_RRIO])
           | (t[4] & (d_q[OP_STA] | d_q[OP_BUN]))
           | (t[5] & (d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_BSA]))
           | (t[6] & d_q[OP_ISZ]);
  end

  // Next-state for run flag, opcode/I latches and sticky error
  always_comb begin
    s_d = s_q;
    if (!s_q && start) begin
      s_d = 1'b1;
    end else if (hlt) begin
      s_d = 1'b0;
    end
    d_d = d_q;
    i_d = i_q;
    if (t[2]) begin
      d_d = onehot3(ir[14:12]);
      i_d = ir[15];
    end
    sc_err_d = sc_err_q | (sc_next == 3'd7);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= (START_RUNNING != 0);
      d_q      <= 8'h00;
      i_q      <= 1'b0;
      sc_err_q <= 1'b0;
    end else begin
      s_q      <= s_d;
      d_q      <= d_d;
      i_q      <= i_d;
      sc_err_q <= sc_err_d;
    end
  end

  // Memory read + DR load at T4 for the operand-fetching instructions
  assign mem_ref_rd = t[4] & (d_q[OP_AND] | d_q[OP_ADD] | d_q[OP_LDA] | d_q[OP_ISZ]);

  // Strobe decode; t is zero while stopped, so every strobe except pc_clr is too
  always_comb begin
    ar_ld_pc  = t[0];
    ir_ld     = t[1];
    ar_ld_ir  = t[2];
    rr_exec   = t[3] & d_q[OP_RRIO] & ~i_q;
    io_exec   = t[3] & d_q[OP_RRIO] & i_q;
    ar_ld_mem = t[3] & ~d_q[OP_RRIO] & i_q;
    mem_rd    = t[1] | ar_ld_mem | mem_ref_rd;
    dr_ld     = mem_ref_rd;
    dr_inc    = t[5] & d_q[OP_ISZ];
    ar_inc    = t[4] & d_q[OP_BSA];
    mem_wr    = (t[4] & (d_q[OP_STA] | d_q[OP_BSA])) | (t[6] & d_q[OP_ISZ]);
    pc_ld     = (t[4] & d_q[OP_BUN]) | (t[5] & d_q[OP_BSA]);
    pc_inc    = t[1] | (t[6] & d_q[OP_ISZ] & dr_zero);
    pc_clr    = (CLR_PC_ON_START != 0) & ~s_q & start;
    ac_op     = AC_NONE;
    if (t[5]) begin
      if (d_q[OP_AND]) ac_op = AC_AND;
      if (d_q[OP_ADD]) ac_op = AC_ADD;
      if (d_q[OP_LDA]) ac_op = AC_LDA;
    end
  end

  assign d       = d_q;
  assign i_bit   = i_q;
  assign running = s_q;
  assign sc_err  = sc_err_q;

endmodule

// File: tb/tb_mano_timing_ctrl.sv
// Directed vector bench for mano_timing_ctrl.
module tb_mano_timing_ctrl;

  localparam logic [13:0] PCLD  = 14'h2000;
  localparam logic [13:0] PCINC = 14'h1000;
  localparam logic [13:0] PCCLR = 14'h0800;
  localparam logic [13:0] ARPC  = 14'h0400;
  localparam logic [13:0] ARIR  = 14'h0200;
  localparam logic [13:0] ARMEM = 14'h0100;
  localparam logic [13:0] ARINC = 14'h0080;
  localparam logic [13:0] IRLD  = 14'h0040;
  localparam logic [13:0] MRD   = 14'h0020;
  localparam logic [13:0] MWR   = 14'h0010;
  localparam logic [13:0] DRLD  = 14'h0008;
  localparam logic [13:0] DRINC = 14'h0004;
  localparam logic [13:0] RR    = 14'h0002;
  localparam logic [13:0] IO    = 14'h0001;
  localparam logic [13:0] FETCH1 = MRD | IRLD | PCINC;
  localparam logic [13:0] NONE  = 14'h0000;

  typedef struct {
    logic        st;
    logic [15:0] ir;
    logic        dz;
    logic [7:0]  t;
    logic [7:0]  d;
    logic        i;
    logic        run;
    logic [13:0] stb;
    logic [1:0]  ac;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] ir;
  logic        dr_zero;
  logic [7:0]  t, d;
  logic        i_bit, running;
  logic        pc_ld, pc_inc, pc_clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc;
  logic        ir_ld, mem_rd, mem_wr, dr_ld, dr_inc, rr_exec, io_exec, sc_err;
  logic [1:0]  ac_op;
  logic [13:0] stb;

  int n_chk  = 0;
  int n_fail = 0;
  int rowno  = 0;

  vec_t vt [24];

  always #5 clk = ~clk;

  mano_timing_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ir        (ir),
    .dr_zero   (dr_zero),
    .t         (t),
    .d         (d),
    .i_bit     (i_bit),
    .running   (running),
    .pc_ld     (pc_ld),
    .pc_inc    (pc_inc),
    .pc_clr    (pc_clr),
    .ar_ld_pc  (ar_ld_pc),
    .ar_ld_ir  (ar_ld_ir),
    .ar_ld_mem (ar_ld_mem),
    .ar_inc    (ar_inc),
    .ir_ld     (ir_ld),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .dr_ld     (dr_ld),
    .dr_inc    (dr_inc),
    .ac_op     (ac_op),
    .rr_exec   (rr_exec),
    .io_exec   (io_exec),
    .sc_err    (sc_err)
  );

  assign stb = {pc_ld, pc_inc, pc_clr, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc,
                ir_ld, mem_rd, mem_wr, dr_ld, dr_inc, rr_exec, io_exec};

  function automatic vec_t mk(logic st, logic [15:0] ir_v, logic dz, logic [7:0] tt,
                              logic [7:0] dd, logic ii, logic rn, logic [13:0] sb,
                              logic [1:0] ac, logic er);
    vec_t v;
    v.st = st; v.ir = ir_v; v.dz = dz; v.t = tt; v.d = dd;
    v.i = ii; v.run = rn; v.stb = sb; v.ac = ac; v.err = er;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h, expected %h", nm, rowno, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1ns later
  task automatic apply_row(input vec_t v);
    @(negedge clk);
    start   = v.st;
    ir      = v.ir;
    dr_zero = v.dz;
    #1;
    $display("row %0d: ir=%h t=%h d=%h i=%b run=%b stb=%h ac=%0d err=%b",
             rowno, ir, t, d, i_bit, running, stb, ac_op, sc_err);
    cmp("t", {8'h00, t}, {8'h00, v.t});
    cmp("d", {8'h00, d}, {8'h00, v.d});
    cmp("i_bit", {15'h0, i_bit}, {15'h0, v.i});
    cmp("running", {15'h0, running}, {15'h0, v.run});
    cmp("strobes", {2'b00, stb}, {2'b00, v.stb});
    cmp("ac_op", {14'h0, ac_op}, {14'h0, v.ac});
    cmp("sc_err", {15'h0, sc_err}, {15'h0, v.err});
    rowno++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // start, then BUN direct
    vt[0]  = mk(1, 16'h0000, 0, 8'h00, 8'h00, 0, 0, PCCLR, 2'd0, 0);
    vt[1]  = mk(0, 16'h4123, 0, 8'h01, 8'h00, 0, 1, ARPC, 2'd0, 0);
    vt[2]  = mk(0, 16'h4123, 0, 8'h02, 8'h00, 0, 1, FETCH1, 2'd0, 0);
    vt[3]  = mk(0, 16'h4123, 0, 8'h04, 8'h00, 0, 1, ARIR, 2'd0, 0);
    vt[4]  = mk(0, 16'h4123, 0, 8'h08, 8'h10, 0, 1, NONE, 2'd0, 0);
    vt[5]  = mk(0, 16'h4123, 0, 8'h10, 8'h10, 0, 1, PCLD, 2'd0, 0);
    // ISZ indirect, DR becomes zero
    vt[6]  = mk(0, 16'hE000, 0, 8'h01, 8'h10, 0, 1, ARPC, 2'd0, 0);
    vt[7]  = mk(0, 16'hE000, 1, 8'h02, 8'h10, 0, 1, FETCH1, 2'd0, 0);
    vt[8]  = mk(0, 16'hE000, 1, 8'h04, 8'h10, 0, 1, ARIR, 2'd0, 0);
    vt[9]  = mk(0, 16'hE000, 1, 8'h08, 8'h40, 1, 1, ARMEM | MRD, 2'd0, 0);
    vt[10] = mk(0, 16'hE000, 1, 8'h10, 8'h40, 1, 1, MRD | DRLD, 2'd0, 0);
    vt[11] = mk(0, 16'hE000, 1, 8'h20, 8'h40, 1, 1, DRINC, 2'd0, 0);
    vt[12] = mk(0, 16'hE000, 1, 8'h40, 8'h40, 1, 1, MWR | PCINC, 2'd0, 0);
    // HLT; start while running ignored; HLT+start same cycle halts
    vt[13] = mk(0, 16'h7001, 0, 8'h01, 8'h40, 1, 1, ARPC, 2'd0, 0);
    vt[14] = mk(0, 16'h7001, 0, 8'h02, 8'h40, 1, 1, FETCH1, 2'd0, 0);
    vt[15] = mk(1, 16'h7001, 0, 8'h04, 8'h40, 1, 1, ARIR, 2'd0, 0);
    vt[16] = mk(1, 16'h7001, 0, 8'h08, 8'h80, 0, 1, RR, 2'd0, 0);
    vt[17] = mk(0, 16'h7001, 0, 8'h00, 8'h80, 0, 0, NONE, 2'd0, 0);
    vt[18] = mk(0, 16'h7001, 0, 8'h00, 8'h80, 0, 0, NONE, 2'd0, 0);
    // restart into BSA
    vt[19] = mk(1, 16'h5010, 0, 8'h00, 8'h80, 0, 0, PCCLR, 2'd0, 0);
    vt[20] = mk(0, 16'h5010, 0, 8'h01, 8'h80, 0, 1, ARPC, 2'd0, 0);
    vt[21] = mk(0, 16'h5010, 0, 8'h02, 8'h80, 0, 1, FETCH1, 2'd0, 0);
    vt[22] = mk(0, 16'h5010, 0, 8'h04, 8'h80, 0, 1, ARIR, 2'd0, 0);
    vt[23] = mk(0, 16'h5010, 0, 8'h08, 8'h20, 0, 1, NONE, 2'd0, 0);

    rst_n = 1'b0; start = 1'b0; ir = 16'h0000; dr_zero = 1'b0;
    @(negedge clk);
    #1;
    cmp("reset_t", {8'h00, t}, 16'h0000);
    cmp("reset_d", {8'h00, d}, 16'h0000);
    cmp("reset_running", {15'h0, running}, 16'h0000);
    cmp("reset_strobes", {2'b00, stb}, 16'h0000);
    cmp("reset_sc_err", {15'h0, sc_err}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 24; k++) begin
      apply_row(vt[k]);
    end

    // BSA T4, then reset mid-instruction
    apply_row(mk(0, 16'h5010, 0, 8'h10, 8'h20, 0, 1, MWR | ARINC, 2'd0, 0));
    #1 rst_n = 1'b0;
    #1;
    $display("row %0d: reset asserted at T4 t=%h stb=%h run=%b", rowno, t, stb, running);
    cmp("abort_t", {8'h00, t}, 16'h0000);
    cmp("abort_strobes", {2'b00, stb}, 16'h0000);
    cmp("abort_running", {15'h0, running}, 16'h0000);
    cmp("abort_d", {8'h00, d}, 16'h0000);
    rowno++;
    @(negedge clk);
    rst_n = 1'b1;

    // full BSA after restart: SC back at 0, T0 right after start
    apply_row(mk(1, 16'h5010, 0, 8'h00, 8'h00, 0, 0, PCCLR, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h01, 8'h00, 0, 1, ARPC, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h02, 8'h00, 0, 1, FETCH1, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h04, 8'h00, 0, 1, ARIR, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h08, 8'h20, 0, 1, NONE, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h10, 8'h20, 0, 1, MWR | ARINC, 2'd0, 0));
    apply_row(mk(0, 16'h5010, 0, 8'h20, 8'h20, 0, 1, PCLD, 2'd0, 0));

    // AND direct with the opcode latch corrupted -> SC runs to T7
    apply_row(mk(0, 16'h0000, 0, 8'h01, 8'h20, 0, 1, ARPC, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h02, 8'h20, 0, 1, FETCH1, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h04, 8'h20, 0, 1, ARIR, 2'd0, 0));
    @(posedge clk);
    #1;
    force dut.d_q = 8'h00;
    apply_row(mk(0, 16'h0000, 0, 8'h08, 8'h00, 0, 1, NONE, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h10, 8'h00, 0, 1, NONE, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h20, 8'h00, 0, 1, NONE, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h40, 8'h00, 0, 1, NONE, 2'd0, 0));
    apply_row(mk(0, 16'h0000, 0, 8'h80, 8'h00, 0, 1, NONE, 2'd0, 1));
    release dut.d_q;
    // sticky error; a clean AND instruction follows
    apply_row(mk(0, 16'h0000, 0, 8'h01, 8'h00, 0, 1, ARPC, 2'd0, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h02, 8'h00, 0, 1, FETCH1, 2'd0, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h04, 8'h00, 0, 1, ARIR, 2'd0, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h08, 8'h01, 0, 1, NONE, 2'd0, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h10, 8'h01, 0, 1, MRD | DRLD, 2'd0, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h20, 8'h01, 0, 1, NONE, 2'd1, 1));
    apply_row(mk(0, 16'h0000, 0, 8'h01, 8'h01, 0, 1, ARPC, 2'd0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
